sat_sweep_controller: RTL
=========================

Name: sat_sweep_controller

Overview:
Sequencer that drives an exhaustive search over the primary inputs of one combinational benchmark circuit with a single `sat` output, such as the multiplier-factorize instances. It steps a candidate assignment through the full input space and waits a programmable settle time per candidate. It samples `sat`, reports each satisfying assignment through a hold/resume handshake, and keeps a count of candidates tried. It sits between the host/control interface and the benchmark netlist.

Parameters:
N_IN, 13, number of benchmark primary inputs; candidate width.
EVAL_LATENCY, 1, cycles between driving a candidate and sampling sat_in; 0 = same-cycle sampling. Legal range 0..15.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin sweep from candidate 0; honoured only in IDLE or DONE
abort  in  1  stop sweep; honoured in SETTLE, SAMPLE and HIT
resume  in  1  continue after a reported hit; honoured only in HIT
sat_in  in  1  sat output of the benchmark under test
cand  out  N_IN  candidate assignment to the benchmark inputs
busy  out  1  high in SETTLE, SAMPLE, HIT
hit  out  1  high in HIT; solution is valid while hit=1
solution  out  N_IN  latched satisfying assignment
found  out  1  at least one hit during this sweep; sticky until the next start
done  out  1  high in DONE
exhausted  out  1  in DONE: 1 = whole space tried, 0 = aborted
tried  out  N_IN+1  number of candidates sampled in this sweep (max 2^N_IN)

Behaviour:
- Fixed decisions: one clock; reset is synchronous and active-high. rst=1 forces IDLE, mid-sweep included. While in reset all outputs are 0, cand=0, tried=0, and the settle counter is cleared.
- States: IDLE, SETTLE, SAMPLE, HIT, DONE.
- IDLE / DONE + start: cand<=0, tried<=0, found<=0, exhausted<=0, then go to SETTLE. DONE outputs hold until start.
- SETTLE: cand is held stable and the settle counter counts EVAL_LATENCY cycles, then the FSM enters SAMPLE. With EVAL_LATENCY=0, SETTLE is skipped: the entry transition goes directly to SAMPLE with the new cand.
- SAMPLE (one cycle), sat_in sampled this cycle:
  - tried<=tried+1.
  - If sat_in=1: solution<=cand, found<=1, go to HIT.
  - Else if cand is all-ones: exhausted<=1, go to DONE.
  - Else: cand<=cand+1, go to SETTLE (or SAMPLE when EVAL_LATENCY=0).
- Throughput is EVAL_LATENCY+1 cycles per candidate.
- HIT: cand and solution are held. On resume:
  - If cand is all-ones: exhausted<=1, go to DONE.
  - Else: cand<=cand+1, go to SETTLE or SAMPLE as above.
- abort has priority over resume and over the sat result. From SETTLE, SAMPLE or HIT the FSM goes to DONE next cycle with exhausted=0. tried does not increment on an abort taken in SAMPLE.
- start while busy is ignored. resume outside HIT is ignored. abort in IDLE or DONE is ignored.
- Wrap-around: cand never wraps. The last candidate is 2^N_IN-1, and tried=2^N_IN after a full sweep with no abort.
- sat_in is sampled only in SAMPLE. Glitches during SETTLE have no effect.

Decomposition:
- Package sat_ctl_pkg contains:
  - state enum sweep_state_t {IDLE, SETTLE, SAMPLE, HIT, DONE};
  - localparam LAT_W=4;
  - a function last_cand(N) returning the all-ones value.
- One sub-module, sat_settle_timer: a load/count-down LAT_W-bit counter with a zero flag, instantiated once. Everything else lives in the top.

Test Plan:
- Benchmark model = sat when a*b==437 with a,b > 1 (cand[7:0]=a, cand[12:8]=b); N_IN=13, EVAL_LATENCY=1; start, resume on each hit:
  - first hit: solution=0x1317 (a=23, b=19), tried=4888;
  - second hit: solution=0x1713 (a=19, b=23), tried=5908;
  - then done=1, exhausted=1, found=1, tried=8192.
- sat_in tied 0, EVAL_LATENCY=0: done rises 8192 cycles after start (SAMPLE each cycle) with found=0, exhausted=1, tried=8192.
- abort held in the same cycle as resume while in HIT at 0x1317: next cycle DONE, exhausted=0, solution=0x1317, tried=4888, cand=0x1317.
- rst asserted while cand=0x0100 in SETTLE: next cycle all outputs 0, IDLE. A new start sweeps from cand=0.
- start pulsed while busy: no effect on cand or tried. sat_in pulsed only during SETTLE with EVAL_LATENCY=3: no hit.
- start from DONE after a sweep: found, exhausted and tried clear, and cand=0 on the following cycle.

Source files
------------

// File: rtl/sat_ctl_pkg.sv
// rtl/sat_ctl_pkg.sv - shared types and helpers for the sat sweep controller
package sat_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        HIT,
        DONE
    } sweep_state_t;

    localparam int LAT_W = 4;

    function automatic logic [31:0] last_cand(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/sat_settle_timer.sv
// rtl/sat_settle_timer.sv - loadable down counter with a zero flag
module sat_settle_timer
    import sat_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             zero
);

    logic [LAT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - LAT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sat_sweep_controller.sv
// rtl/sat_sweep_controller.sv - exhaustive candidate sweep with settle delay and hit handshake
module sat_sweep_controller
    import sat_ctl_pkg::*;
#(
    parameter int N_IN         = 13,
    parameter int EVAL_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            resume,
    input  logic            sat_in,
    output logic [N_IN-1:0] cand,
    output logic            busy,
    output logic            hit,
    output logic [N_IN-1:0] solution,
    output logic            found,
    output logic            done,
    output logic            exhausted,
    output logic [N_IN:0]   tried
);

    localparam logic [31:0]      LAST32      = last_cand(N_IN);
    localparam logic [N_IN-1:0]  LAST        = LAST32[N_IN-1:0];
    localparam logic [N_IN-1:0]  CAND_ONE    = 1;
    localparam logic [N_IN:0]    TRIED_ONE   = 1;
    localparam logic [LAT_W-1:0] SETTLE_LOAD = (EVAL_LATENCY > 0) ? LAT_W'(EVAL_LATENCY - 1) : '0;
    // With zero latency the settle phase is bypassed entirely.
    localparam sweep_state_t     EVAL_STATE  = (EVAL_LATENCY == 0) ? SAMPLE : SETTLE;

    sweep_state_t state, next_state;
    logic         settle_zero;
    logic         timer_load;
    logic         at_last;

    assign at_last    = (cand == LAST);
    assign timer_load = (next_state == SETTLE) && (state != SETTLE);

    sat_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .zero     (settle_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start) next_state = EVAL_STATE;
            end
            SETTLE: begin
                if (abort)            next_state = DONE;
                else if (settle_zero) next_state = SAMPLE;
            end
            SAMPLE: begin
                if (abort)        next_state = DONE;
                else if (sat_in)  next_state = HIT;
                else if (at_last) next_state = DONE;
                else              next_state = EVAL_STATE;
            end
            HIT: begin
                if (abort)       next_state = DONE;
                else if (resume) next_state = at_last ? DONE : EVAL_STATE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SETTLE) || (state == SAMPLE) || (state == HIT);
        hit  = (state == HIT);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand      <= '0;
            tried     <= '0;
            solution  <= '0;
            found     <= 1'b0;
            exhausted <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cand      <= '0;
                        tried     <= '0;
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                    end
                end
                SAMPLE: begin
                    if (!abort) begin
                        tried <= tried + TRIED_ONE;
                        if (sat_in) begin
                            solution <= cand;
                            found    <= 1'b1;
                        end else if (at_last) begin
                            exhausted <= 1'b1;
                        end else begin
                            cand <= cand + CAND_ONE;
                        end
                    end
                end
                HIT: begin
                    if (!abort && resume) begin
                        if (at_last) exhausted <= 1'b1;
                        else         cand      <= cand + CAND_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
